vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Source end of the pixel-timing bus that every draw_* stage consumes and forwards.
//  Free-running H/V counters generate hcount/vcount/hsync/hblnk/vsync/vblnk for XGA 1024x768@60 (65 MHz pclk).
//  Sits at the head of the draw pipeline; its outputs feed the first draw stage directly.
//  Adds a one-cycle frame_start strobe for game-logic frame ticks.
// PARAMETERS
//  H_ACTIVE   1024  visible pixels per line
//  H_FP       24    horizontal front porch, pixels
//  H_SYNC     136   hsync width, pixels
//  H_BP       160   horizontal back porch, pixels (H_TOTAL = 1344)
//  V_ACTIVE   768   visible lines per frame
//  V_FP       3     vertical front porch, lines
//  V_SYNC     6     vsync width, lines
//  V_BP       29    vertical back porch, lines (V_TOTAL = 806)
//  HSYNC_POL  0     active level of hsync (0 = active-low, VESA XGA)
//  VSYNC_POL  0     active level of vsync
// PORTS
//  pclk         in   1   pixel clock, all logic on rising edge
//  rst          in   1   synchronous reset, active-high
//  hcount_out   out  11  pixel index in line, 0..H_TOTAL-1
//  vcount_out   out  11  line index in frame, 0..V_TOTAL-1
//  hsync_out    out  1   horizontal sync, level per HSYNC_POL
//  hblnk_out    out  1   1 when hcount_out >= H_ACTIVE
//  vsync_out    out  1   vertical sync, level per VSYNC_POL
//  vblnk_out    out  1   1 when vcount_out >= V_ACTIVE
//  frame_start  out  1   1-cycle pulse while outputs show pixel (0,0)
// BEHAVIOUR
//  - All outputs are registered. Every decode is computed from the next counter value,
//    so all seven outputs describe the same pixel in the same cycle, with no skew.
//  - Reset, while rst=1 at an edge:
//    - hcount_out=0, vcount_out=0, hblnk_out=0, vblnk_out=0, frame_start=0.
//    - hsync_out=~HSYNC_POL, vsync_out=~VSYNC_POL, i.e. both sync outputs inactive.
//  - Counting, each non-reset edge:
//    - hcount increments by 1. At H_TOTAL-1 it wraps to 0 and vcount advances.
//    - vcount increments only on an hcount wrap. At V_TOTAL-1 (with an hcount wrap) it wraps to 0.
//    - Counters never reach H_TOTAL or V_TOTAL. Comparisons are unsigned, 11 bits.
//  - Decodes, on the registered count values:
//    - hblnk = hcount >= H_ACTIVE.
//    - hsync active when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, i.e. 1048..1183.
//    - vblnk = vcount >= V_ACTIVE.
//    - vsync active when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, i.e. 771..776.
//    - vsync/vblnk change only together with vcount, on the edge where hcount goes to 0.
//  - frame_start:
//    - 1 for exactly one cycle when (hcount_out, vcount_out) = (0,0), having wrapped from (1343,805).
//    - Not asserted for the (0,0) state held by reset. The first pulse comes one full frame after reset release.
//  - Reset mid-frame: the next edge forces the reset values. Counting restarts from (0,0) with no partial-frame pulse.
//  - First edge after rst falls: outputs show (1,0).
//  - No other inputs; the generator is free-running. Period = 1344*806 = 1,083,264 pclk.
// TESTING
//  1. rst high 5 cycles:
//     - hcount/vcount=0, hsync=vsync=1, blanks=0, frame_start=0.
//     - Release: next cycle hcount=1, vcount=0.
//  2. Line sweep:
//     - hblnk rises when hcount=1024.
//     - hsync falls at 1048 and rises at 1184.
//     - hcount 1343 -> 0 with vcount 0 -> 1 in the same cycle.
//  3. Frame sweep:
//     - vblnk=1 from vcount=768.
//     - vsync low for vcount 771..776 only.
//     - vcount 805 -> 0 with hcount 1343 -> 0.
//  4. frame_start:
//     - Exactly one pulse per 1,083,264 cycles, first one 1,083,263 edges after release.
//     - Coincides with hcount=vcount=0 and hblnk=vblnk=0.
//  5. Mid-frame reset:
//     - Assert rst at (500,400): next cycle all outputs at reset values.
//     - After release, counting restarts at (1,0); no spurious frame_start.
//  6. Polarity: HSYNC_POL=VSYNC_POL=1 build.
//     - Sync outputs are 0 in reset and high only in 1048..1183 / 771..776.
//     - Counters are identical to the default build.

Source files
------------

// File: rtl/vga_timing_gen.sv
// XGA 1024x768@60 pixel-timing source: free-running H/V counters with registered
// sync/blank decodes and a one-cycle frame_start tick at pixel (0,0).
module vga_timing_gen #(
  parameter int   H_ACTIVE  = 1024,
  parameter int   H_FP      = 24,
  parameter int   H_SYNC    = 136,
  parameter int   H_BP      = 160,
  parameter int   V_ACTIVE  = 768,
  parameter int   V_FP      = 3,
  parameter int   V_SYNC    = 6,
  parameter int   V_BP      = 29,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic        pclk,
  input  logic        rst,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_BLANK      = 11'(H_ACTIVE);
  localparam logic [10:0] V_BLANK      = 11'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hcount_reg, hcount_next;
  logic [10:0] vcount_reg, vcount_next;
  logic        hsync_reg, hblnk_reg, vsync_reg, vblnk_reg, frame_start_reg;

  always_comb begin
    hcount_next = (hcount_reg == H_LAST) ? 11'd0 : hcount_reg + 11'd1;
    vcount_next = vcount_reg;
    if (hcount_reg == H_LAST) begin
      vcount_next = (vcount_reg == V_LAST) ? 11'd0 : vcount_reg + 11'd1;
    end
  end

  // Decodes look at the next count so every output describes the same pixel.
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_reg      <= 11'd0;
      vcount_reg      <= 11'd0;
      hblnk_reg       <= 1'b0;
      vblnk_reg       <= 1'b0;
      hsync_reg       <= ~HSYNC_POL;
      vsync_reg       <= ~VSYNC_POL;
      frame_start_reg <= 1'b0;
    end else begin
      hcount_reg      <= hcount_next;
      vcount_reg      <= vcount_next;
      hblnk_reg       <= (hcount_next >= H_BLANK);
      vblnk_reg       <= (vcount_next >= V_BLANK);
      hsync_reg       <= ((hcount_next >= H_SYNC_START) && (hcount_next < H_SYNC_END))
                         ? HSYNC_POL : ~HSYNC_POL;
      vsync_reg       <= ((vcount_next >= V_SYNC_START) && (vcount_next < V_SYNC_END))
                         ? VSYNC_POL : ~VSYNC_POL;
      // Reset holds (0,0) but the next count from there is (1,0), so no pulse leaks out.
      frame_start_reg <= (hcount_next == 11'd0) && (vcount_next == 11'd0);
    end
  end

  assign hcount_out  = hcount_reg;
  assign vcount_out  = vcount_reg;
  assign hsync_out   = hsync_reg;
  assign hblnk_out   = hblnk_reg;
  assign vsync_out   = vsync_reg;
  assign vblnk_out   = vblnk_reg;
  assign frame_start = frame_start_reg;

endmodule
